// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

   typedef logic [31:0] word_t;

   // Padder control states, also exported on the debug port.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      PAD   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam word_t PAD_WORD = 32'h8000_0000;

   // Number of 512-bit blocks needed for a message of 'words' 32-bit words:
   // the message, one pad word and the two-word length field must fit.
   function automatic int num_blocks(input int words);
      return (words + 2) / 16 + 1;
   endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Schedule-word stream from the padder to the compression core.
//
// Handshake: a word moves on a rising clk edge where w_valid and w_ready are
// both 1. Once w_valid is raised it stays high, and w_data, w_idx and
// w_last_block stay unchanged, until that transfer happens. w_ready may
// change freely and never depends combinationally on w_valid.
interface sha256_msg_padder_if;
   import sha256_pkg::*;

   logic       w_valid;
   logic       w_ready;
   word_t      w_data;
   logic [3:0] w_idx;
   logic       w_last_block;

   modport master (output w_valid, output w_data, output w_idx,
                   output w_last_block, input w_ready);
   modport slave  (input w_valid, input w_data, input w_idx,
                   input w_last_block, output w_ready);
endinterface

// File: rtl/sha256_word_skid.sv
// Two-entry skid buffer holding memory words between the one-cycle-latency
// read port and the output handshake. The producer only pushes when it has
// reserved a slot, so a push never lands on a full buffer.
module sha256_word_skid
   import sha256_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  word_t      in_data,
   output logic       out_valid,
   output word_t      out_data,
   input  logic       out_ready,
   output logic [1:0] count
);

   word_t      slot0;
   word_t      slot1;
   logic [1:0] cnt;
   logic       pop;

   assign pop       = out_ready && (cnt != 2'd0);
   assign out_valid = (cnt != 2'd0);
   assign out_data  = slot0;
   assign count     = cnt;

   // slot0 is always the head; slot1 holds the word behind it.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= 2'd0;
         slot0 <= '0;
         slot1 <= '0;
      end else begin
         case ({in_valid, pop})
            2'b10: begin
               if (cnt == 2'd0) slot0 <= in_data;
               else             slot1 <= in_data;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               cnt   <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  slot0 <= in_data;
               end else begin
                  slot0 <= slot1;
                  slot1 <= in_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: streams NUM_OF_WORDS memory words followed by the
// 0x80000000 pad word, zero fill and the 64-bit bit-length field as 16-word
// blocks. Optional macro SHA256_PADDER_BYTESWAP_EN byte-reverses each memory
// word before emission (pad and length words are never swapped).
module sha256_msg_padder
   import sha256_pkg::*;
#(
   parameter int NUM_OF_WORDS = 40
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [15:0]                message_addr,
   output logic                       mem_clk,
   output logic                       mem_we,
   output logic [15:0]                mem_addr,
   input  word_t                      mem_read_data,
   sha256_msg_padder_if.master        w,
   output logic                       done,
   output state_t                     dbg_state
);

   localparam int          BLOCKS     = num_blocks(NUM_OF_WORDS);
   localparam logic [15:0] MSG_LEN    = 16'(NUM_OF_WORDS);
   localparam logic [15:0] LAST_MSG   = 16'(NUM_OF_WORDS - 1);
   localparam logic [15:0] FINAL_IDX  = 16'(16 * BLOCKS - 1);
   localparam logic [15:0] LAST_BASE  = 16'(16 * (BLOCKS - 1));
   localparam word_t       LEN_WORD   = word_t'(NUM_OF_WORDS * 32);

   state_t      state, state_nxt;
   logic [15:0] rd_addr;
   logic [15:0] rd_cnt;
   logic        rd_pend;
   logic [15:0] out_cnt;
   logic        start_ok;
   logic        issue;
   logic        xfer;
   logic        fetch_pop;
   logic        out_valid;
   word_t       out_data;
   word_t       push_data;
   logic        skid_valid;
   word_t       skid_data;
   logic [1:0]  skid_cnt;
   logic [2:0]  occ;

   assign mem_clk   = clk;
   assign mem_we    = 1'b0;
   assign mem_addr  = rd_addr;
   assign done      = (state == DONE);
   assign dbg_state = state;

`ifdef SHA256_PADDER_BYTESWAP_EN
   assign push_data = {mem_read_data[7:0], mem_read_data[15:8],
                       mem_read_data[23:16], mem_read_data[31:24]};
`else
   assign push_data = mem_read_data;
`endif

   sha256_word_skid u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (rd_pend),
      .in_data   (push_data),
      .out_valid (skid_valid),
      .out_data  (skid_data),
      .out_ready (fetch_pop),
      .count     (skid_cnt)
   );

   assign fetch_pop = (state == FETCH) && w.w_ready;

   // Read credit: words buffered plus the read in flight, minus the word
   // leaving this cycle, must stay below two.
   assign occ   = {1'b0, skid_cnt} + {2'b00, rd_pend};
   assign issue = (state == FETCH) && (rd_cnt < MSG_LEN) &&
                  (occ < (3'd2 + {2'b00, xfer}));

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Output word selection and next-state decode.
   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      case (state)
         FETCH: begin
            out_valid = skid_valid;
            out_data  = skid_data;
         end
         PAD: begin
            out_valid = 1'b1;
            if (out_cnt == MSG_LEN)        out_data = PAD_WORD;
            else if (out_cnt == FINAL_IDX) out_data = LEN_WORD;
            else                           out_data = '0;
         end
         default: ;
      endcase
      xfer = out_valid && w.w_ready;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               start_ok  = 1'b1;
               state_nxt = FETCH;
            end
         end
         FETCH: if (xfer && (out_cnt == LAST_MSG))  state_nxt = PAD;
         PAD:   if (xfer && (out_cnt == FINAL_IDX)) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   assign w.w_valid      = out_valid;
   assign w.w_data       = out_data;
   assign w.w_idx        = out_cnt[3:0];
   assign w.w_last_block = ((state == FETCH) || (state == PAD)) &&
                           (out_cnt >= LAST_BASE);

   // Read address, read count and emitted-word counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_addr <= '0;
         rd_cnt  <= '0;
         rd_pend <= 1'b0;
         out_cnt <= '0;
      end else begin
         rd_pend <= issue;
         if (start_ok) begin
            rd_addr <= message_addr;
            rd_cnt  <= '0;
            out_cnt <= '0;
         end else begin
            if (issue) begin
               rd_addr <= rd_addr + 16'd1;
               rd_cnt  <= rd_cnt + 16'd1;
            end
            if (xfer) out_cnt <= out_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: NUM=40 and NUM=14 instances sharing
// one word-addressed memory, streams checked word by word against a queue of
// expected words built from the padding rules.
module tb_sha256_msg_padder;
   import sha256_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_a, start_b;
   logic [15:0] addr_a, addr_b;
   logic        mem_clk_a, mem_clk_b, mem_we_a, mem_we_b;
   logic [15:0] mem_addr_a, mem_addr_b;
   word_t       rd_a, rd_b;
   logic        done_a, done_b;
   state_t      dbg_a, dbg_b;

   sha256_msg_padder_if if_a();
   sha256_msg_padder_if if_b();

   word_t       mem [0:65535];
   logic [31:0] exp_q[$];
   word_t       got_q[$];
   logic [15:0] addr_q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc_n;

   logic        sel_v;
   logic        cur_valid, cur_last, cur_done;
   word_t       cur_data;
   logic [3:0]  cur_idx;
   logic [15:0] cur_addr;
   state_t      cur_state;

   // Clock.
   always #5 clk = ~clk;

   sha256_msg_padder #(.NUM_OF_WORDS(40)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .message_addr(addr_a),
      .mem_clk(mem_clk_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
      .mem_read_data(rd_a), .w(if_a), .done(done_a), .dbg_state(dbg_a));

   sha256_msg_padder #(.NUM_OF_WORDS(14)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .message_addr(addr_b),
      .mem_clk(mem_clk_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
      .mem_read_data(rd_b), .w(if_b), .done(done_b), .dbg_state(dbg_b));

   // Synchronous memory: data one clock after the address.
   always @(posedge mem_clk_a) rd_a <= mem[mem_addr_a];
   always @(posedge mem_clk_b) rd_b <= mem[mem_addr_b];

   // Observe the selected instance.
   always_comb begin
      cur_valid = sel_v ? if_b.w_valid      : if_a.w_valid;
      cur_data  = sel_v ? if_b.w_data       : if_a.w_data;
      cur_idx   = sel_v ? if_b.w_idx        : if_a.w_idx;
      cur_last  = sel_v ? if_b.w_last_block : if_a.w_last_block;
      cur_done  = sel_v ? done_b            : done_a;
      cur_addr  = sel_v ? mem_addr_b        : mem_addr_a;
      cur_state = sel_v ? dbg_b             : dbg_a;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic word_t seq_word(input int i);
      word_t v = 32'h0123_4675;
      for (int j = 0; j < i; j++) v = {v[30:0], v[31]};
      return v;
   endfunction

   function automatic word_t exp_mem(input int i);
      word_t v = seq_word(i);
`ifdef SHA256_PADDER_BYTESWAP_EN
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
`else
      return v;
`endif
   endfunction

   task automatic build_exp(input int n_msg);
      int total = 16 * num_blocks(n_msg);
      exp_q.delete();
      for (int k = 0; k < total; k++) begin
         if (k < n_msg)           exp_q.push_back(exp_mem(k));
         else if (k == n_msg)     exp_q.push_back(32'h8000_0000);
         else if (k == total - 1) exp_q.push_back(32'(n_msg * 32));
         else                     exp_q.push_back(32'h0);
      end
   endtask

   task automatic do_start(input logic sel, input logic [15:0] addr);
      @(posedge clk); #1;
      if (sel) begin start_b = 1'b1; addr_b = addr; end
      else     begin start_a = 1'b1; addr_a = addr; end
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic run_stream(input logic sel, input int n_msg, input logic rnd,
                             input int abort_at, input int poke_at, output int cycles);
      int k, cyc, first_v, total, last_base;
      logic r, held_v;
      word_t held_d, e;
      logic [3:0] held_i;
      k = 0; cyc = 0; first_v = -1;
      total = 16 * num_blocks(n_msg);
      last_base = total - 16;
      held_v = 1'b0; held_d = '0; held_i = '0;
      sel_v = sel;
      got_q.delete();
      addr_q.delete();
      while (k < total && k != abort_at && cyc < 2000) begin
         @(posedge clk); #1;
         r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (sel) if_b.w_ready = r;
         else     if_a.w_ready = r;
         if (!sel) start_a = (k == poke_at);
         @(negedge clk);
         cyc++;
         addr_q.push_back(cur_addr);
         check("done_low_in_stream", 32'(cur_done), 32'd0);
         if (held_v) begin
            check("stall_valid_held", 32'(cur_valid), 32'd1);
            check("stall_data_held", cur_data, held_d);
            check("stall_idx_held", 32'(cur_idx), 32'(held_i));
         end
         if (cur_valid && first_v < 0) first_v = cyc;
         if (cur_valid && r) begin
            e = exp_q.pop_front();
            check("w_data", cur_data, e);
            check("w_idx", 32'(cur_idx), 32'(k % 16));
            check("w_last_block", 32'(cur_last), 32'(k >= last_base));
            got_q.push_back(cur_data);
            k++;
            held_v = 1'b0;
         end else begin
            held_v = cur_valid;
            held_d = cur_data;
            held_i = cur_idx;
         end
      end
      start_a = 1'b0;
      check("stream_no_timeout", 32'(cyc < 2000), 32'd1);
      check("first_valid_latency", 32'(first_v >= 1 && first_v <= 2), 32'd1);
      cycles = cyc;
   endtask

   task automatic check_done(input logic sel);
      @(posedge clk); #1;
      if (sel) if_b.w_ready = 1'b0;
      else     if_a.w_ready = 1'b0;
      @(negedge clk);
      check("done_after_last", 32'(cur_done), 32'd1);
      check("valid_low_in_done", 32'(cur_valid), 32'd0);
      check("state_done", 32'(cur_state), 32'(DONE));
      @(negedge clk);
      check("done_holds", 32'(cur_done), 32'd1);
   endtask

   task automatic check_reset_vals(input logic sel);
      sel_v = sel;
      #0;
      check("rst_valid", 32'(cur_valid), 32'd0);
      check("rst_done", 32'(cur_done), 32'd0);
      check("rst_mem_addr", 32'(cur_addr), 32'd0);
      check("rst_idx", 32'(cur_idx), 32'd0);
      check("rst_last", 32'(cur_last), 32'd0);
      check("rst_data", cur_data, 32'd0);
      check("rst_state", 32'(cur_state), 32'(IDLE));
   endtask

   // Directed test sequence.
   initial begin
      logic [15:0] a;
      reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
      addr_a = '0; addr_b = '0; sel_v = 1'b0;
      if_a.w_ready = 1'b0; if_b.w_ready = 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] = 32'hDEAD_BEEF;
      for (int i = 0; i < 40; i++) begin
         mem[16'h0100 + i] = seq_word(i);
         a = 16'hFFFE + 16'(i);
         mem[a] = seq_word(i);
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_vals(1'b0);
      check_reset_vals(1'b1);
      check("mem_we_const", 32'(mem_we_a), 32'd0);

      // NUM=40, full-rate stream.
      build_exp(40);
      do_start(1'b0, 16'h0100);
      run_stream(1'b0, 40, 1'b0, -1, -1, cyc_n);
      check("throughput_40", 32'(cyc_n), 32'd49);
`ifdef SHA256_PADDER_BYTESWAP_EN
      check("word0_swapped", got_q[0], 32'h7546_2301);
`else
      check("word0", got_q[0], 32'h0123_4675);
`endif
      check("word40_pad", got_q[40], 32'h8000_0000);
      for (int i = 41; i <= 46; i++) check("word41_46_zero", got_q[i], 32'h0);
      check("word47_len", got_q[47], 32'h0000_0500);
      check_done(1'b0);

      // NUM=40, random backpressure, restarted from DONE.
      build_exp(40);
      do_start(1'b0, 16'h0100);
      run_stream(1'b0, 40, 1'b1, -1, -1, cyc_n);
      check_done(1'b0);

      // Reset after word 20 is accepted, then a clean restart.
      build_exp(40);
      do_start(1'b0, 16'h0100);
      run_stream(1'b0, 40, 1'b0, 21, -1, cyc_n);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check_reset_vals(1'b0);
      build_exp(40);
      do_start(1'b0, 16'h0100);
      run_stream(1'b0, 40, 1'b0, -1, -1, cyc_n);
      check("throughput_restart", 32'(cyc_n), 32'd49);
      check_done(1'b0);

      // Address wrap at 16'hFFFE with a stray start pulse during FETCH.
      build_exp(40);
      do_start(1'b0, 16'hFFFE);
      @(negedge clk);
      check("wrap_addr0", 32'(mem_addr_a), 32'h0000_FFFE);
      run_stream(1'b0, 40, 1'b0, -1, 10, cyc_n);
      check("wrap_addr1", 32'(addr_q[0]), 32'h0000_FFFF);
      check("wrap_addr2", 32'(addr_q[1]), 32'h0000_0000);
      check("throughput_wrap", 32'(cyc_n), 32'd49);
      check_done(1'b0);

      // NUM=14 needs two blocks.
      build_exp(14);
      do_start(1'b1, 16'h0100);
      run_stream(1'b1, 14, 1'b0, -1, -1, cyc_n);
      check("throughput_14", 32'(cyc_n), 32'd33);
      check("n14_word14_pad", got_q[14], 32'h8000_0000);
      for (int i = 15; i <= 30; i++) check("n14_zero", got_q[i], 32'h0);
      check("n14_word31_len", got_q[31], 32'h0000_01C0);
      check_done(1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sha256_msg_padder.md
SHA256_MSG_PADDER -- requirements
Module: sha256_msg_padder

Interface
REQ-001 Parameter NUM_OF_WORDS, default 40: message length in 32-bit words, range 1..1024.
REQ-002 clk  input  1  single clock; all logic on posedge clk; mem_clk is driven from it.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  begin one message; sampled only in IDLE or DONE.
REQ-005 message_addr  input  16  word address of message word 0; captured on accepted start.
REQ-006 mem_clk  output  1  equals clk.
REQ-007 mem_we  output  1  constant 0 (read-only port).
REQ-008 mem_addr  output  16  read address.
REQ-009 mem_read_data  input  32  read data, valid one clk after mem_addr is presented.
REQ-010 w_valid  output  1  w_data holds a schedule word.
REQ-011 w_ready  input  1  downstream compression core accepts the word this cycle.
REQ-012 w_data  output  32  padded message word.
REQ-013 w_idx  output  4  word index within the current 512-bit block, 0..15.
REQ-014 w_last_block  output  1  current word belongs to the final block.
REQ-015 done  output  1  all padded words have been accepted.

Function
REQ-016 BLOCKS = (NUM_OF_WORDS+2)/16 + 1 (integer division); total emitted words = 16*BLOCKS.
REQ-017 Stream order: words 0..NUM_OF_WORDS-1 from mem[message_addr+i]; word NUM_OF_WORDS = 32'h80000000; zeros up to word 16*BLOCKS-3; word 16*BLOCKS-2 = 0; word 16*BLOCKS-1 = NUM_OF_WORDS*32.
REQ-018 FSM states: IDLE, FETCH (memory words), PAD (constant words), DONE; transitions IDLE/DONE->FETCH on start, FETCH->PAD after word NUM_OF_WORDS-1 is accepted, PAD->DONE after the final word is accepted.
REQ-019 A word transfers only when w_valid and w_ready are both 1; w_data, w_idx and w_last_block are held stable while w_valid=1 and w_ready=0.
REQ-020 At zero backpressure, throughput is one word per cycle; first w_valid occurs no later than 2 cycles after start is accepted.
REQ-021 Memory reads never run more than 2 words ahead of accepted words; no word is dropped or duplicated under any w_ready pattern.
REQ-022 w_idx wraps 15->0 at each block boundary; w_last_block=1 for exactly the final 16 words.
REQ-023 done asserts the cycle after the final transfer and holds until the next accepted start or reset.
REQ-024 start in FETCH or PAD is ignored.
REQ-025 mem_addr increments modulo 2^16 (wraps from 16'hFFFF to 0).

Reset
REQ-026 When reset=1, the next state is IDLE; w_valid=0, done=0, mem_addr=0, w_idx=0, w_last_block=0, w_data=0, and the skid buffer is emptied.
REQ-027 Reset mid-message aborts the message with no further transfers; the next start restarts from word 0.

Configuration
REQ-028 Macro SHA256_PADDER_BYTESWAP_EN: when defined, each memory word is byte-reversed before emission (padding and length words are not swapped); when undefined, memory words pass through unchanged.

Structure
REQ-029 Package sha256_pkg holds word_t (32-bit), PAD_WORD = 32'h80000000, and function num_blocks(words).
REQ-030 One sub-module, sha256_word_skid: 2-entry valid/ready skid buffer that absorbs the 1-cycle read latency under backpressure.

Verification
REQ-031 NUM=40, seed 32'h01234675 (each word is the previous word rotated left by 1), w_ready=1 -> 48 words; word 40 = 80000000; words 41..46 = 0; word 47 = 00000500; w_last_block=1 on words 32..47 only; done rises after word 47.
REQ-032 NUM=14 -> 2 blocks; word 14 = 80000000; words 15..30 = 0; word 31 = 000001C0.
REQ-033 NUM=40, w_ready random (50%) -> word sequence identical to REQ-031; w_data stable throughout every stall.
REQ-034 reset pulsed after word 20 is accepted -> w_valid=0 and done=0 the following cycle; a new start yields the full REQ-031 sequence.
REQ-035 start pulsed during FETCH -> no effect on the stream; message_addr=16'hFFFE -> reads 16'hFFFE, 16'hFFFF, 16'h0000, ...
REQ-036 With SHA256_PADDER_BYTESWAP_EN defined, mem word 01234675 -> w_data 75462301; pad word remains 80000000.
